text_console_writer: RTL and testbench
======================================

# text_console_writer

Character-stream front end for the text-mode display. Accepts one character at a time with colour and invert attributes over a valid/ready handshake and writes the 16-bit glyph entry into the shared 80x30 text VRAM: 1200 words of 32 bits, two characters per word, 40 words per row. It tracks the cursor, interprets a small control-character set, scrolls the screen up by one row, and clears the screen. The display scanout reads the same VRAM through its own port.

## Interface
- Parameters: none. Geometry is fixed at 80 columns x 30 rows, 40 words per row, 1200 words.
- Clk  in  1  system clock, shared with the VRAM write/read port.
- Reset  in  1  synchronous, active-high.
- char_valid  in  1  char_in and attributes are valid.
- char_ready  out  1  writer can accept a character this cycle.
- char_in  in  8  ASCII code.
- fcolor_idx  in  4  foreground palette index.
- bcolor_idx  in  4  background palette index.
- invert  in  1  glyph invert bit.
- vram_addr  out  11  word address, used for both reads and writes.
- vram_wdata  out  32  write data.
- vram_byteen  out  4  byte enables. Bytes 1:0 are the even-column char; bytes 3:2 are the odd-column char.
- vram_we  out  1  write strobe.
- vram_rdata  in  32  read data, valid one cycle after vram_addr is presented.
- cursor_col  out  7  current column, 0..79.
- cursor_row  out  5  current row, 0..29.
- busy  out  1  scroll or clear in progress.

## Operation
- Entry format, 16 bits: [15] invert, [14:8] char_in[6:0], [7:4] fcolor_idx, [3:2..0] bcolor_idx.
- Even column: entry goes on wdata[15:0] with byteen 4'b0011. Odd column: entry goes on wdata[31:16] with byteen 4'b1100. The unused half of wdata is 0.
- Word address = cursor_row*40 + cursor_col[6:1].
- A character is accepted on char_valid && char_ready. Attributes are latched with it.
- Printable, 0x20..0x7E:
  - Write the entry at the cursor, then advance col by 1.
  - At col 79: col becomes 0 and row increments.
  - If the row was 29: row stays 29 and a scroll runs.
- 0x0A: col becomes 0 and row increments, with the same scroll rule at row 29. No VRAM write.
- 0x0D: col becomes 0. No write.
- 0x08: if col>0, col decrements. Else if row>0, col becomes 79 and row decrements. At (0,0) it does nothing. No erase.
- 0x0C: clear all 1200 words, then cursor goes to (0,0).
- Any other code is consumed and ignored.
- Blank word = {1'b0,7'h20,f,b, 1'b0,7'h20,f,b}, using the attributes latched with the triggering character. Written with byteen 4'hF.
- FSM states: IDLE, WRITE, SCROLL_RD, SCROLL_WR, SCROLL_CLR, CLEAR.
  - IDLE: char_ready=1.
    - Printable -> WRITE.
    - 0x0A at row 29 -> SCROLL_RD.
    - 0x0C -> CLEAR.
    - All other characters update the cursor and stay in IDLE.
  - WRITE: one cycle with vram_we=1. Then -> SCROLL_RD if wrapping off row 29, else -> IDLE.
  - SCROLL_RD / SCROLL_WR: 11-bit counter i runs 0..1159.
    - SCROLL_RD drives addr=i+40 with we=0.
    - SCROLL_WR drives addr=i, wdata=vram_rdata, byteen=4'hF, we=1. Then i increments.
    - After i=1159, reset the counter to 1160 and go to SCROLL_CLR.
  - SCROLL_CLR: blank word to addr 1160..1199, one per cycle. Then -> IDLE.
  - CLEAR: blank word to addr 0..1199, one per cycle. Then -> IDLE.
- busy=1 in SCROLL_*/CLEAR. char_ready=0 in every state except IDLE.

## Timing
- Reset values: state IDLE, cursor (0,0), vram_we=0, vram_addr=0, vram_wdata=0, vram_byteen=0, busy=0, char_ready=1 from the first cycle after reset. VRAM contents are not touched.
- Printable accepted in cycle N: vram_we=1 in N+1, cursor updated at the end of N+1, char_ready=1 again in N+2. Throughput is one character per 2 cycles.
- Cursor-only control character accepted in N: cursor updated at the end of N, char_ready stays 1 in N+1.
- Scroll length is 2*1160+40 = 2360 cycles. Clear length is 1200 cycles. char_ready returns the cycle after the last write.
- Outputs are registered. vram_we is never asserted in IDLE.
- Reset mid-scroll or mid-clear: abort in the next cycle, with all outputs at their reset values. A partially modified VRAM is acceptable.
- char_valid held while char_ready=0: no acceptance, no side effects.

## Test plan
- Reset, then 'A' (0x41), f=3, b=0, inv=0 -> N+1: addr 0, byteen 0011, wdata 32'h0000_4130. Cursor becomes (1,0).
- Then 'B' with inv=1, f=3, b=0 -> addr 0, byteen 1100, wdata 32'hC230_0000. Cursor becomes (2,0).
- Cursor at (79,5), send 'x' -> write to addr 239 in the high half. Cursor becomes (0,6), no scroll.
- Cursor at (5,29), send 0x0A -> busy for 2360 cycles.
  - VRAM model word i equals the old word i+40 for i<1160.
  - Words 1160..1199 are blank.
  - Cursor becomes (0,29).
- Send 0x0C with f=7, b=1 -> 1200 writes of 32'h2071_2071. Cursor becomes (0,0).
- At (0,0) send 0x08 and 0x07 -> no writes, cursor stays (0,0). Assert Reset during CLEAR -> next cycle we=0, busy=0, char_ready=1.

Source files
------------

// File: rtl/text_console_writer_if.sv
// Character stream and text-VRAM port bundle of the text console writer.
interface text_console_writer_if;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  char_in;
  logic [3:0]  fcolor_idx;
  logic [3:0]  bcolor_idx;
  logic        invert;
  logic [10:0] vram_addr;
  logic [31:0] vram_wdata;
  logic [3:0]  vram_byteen;
  logic        vram_we;
  logic [31:0] vram_rdata;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  // Writer side: consumes characters, owns the VRAM write/read port
  modport slave (
    input  char_valid, char_in, fcolor_idx, bcolor_idx, invert, vram_rdata,
    output char_ready, vram_addr, vram_wdata, vram_byteen, vram_we,
           cursor_col, cursor_row, busy
  );

  // Source side: produces characters and models the VRAM
  modport master (
    output char_valid, char_in, fcolor_idx, bcolor_idx, invert, vram_rdata,
    input  char_ready, vram_addr, vram_wdata, vram_byteen, vram_we,
           cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/text_console_writer.sv
// Text console writer: turns a character stream into glyph writes on the
// 80x30 text VRAM (two 16-bit entries per 32-bit word), keeps the cursor,
// handles CR/LF/BS/FF, scrolls up by one row and clears the screen.
module text_console_writer (
  input  logic                 i_clk,
  input  logic                 i_rst,
  text_console_writer_if.slave bus
);
  localparam logic [6:0]  LAST_COL    = 7'd79;
  localparam logic [4:0]  LAST_ROW    = 5'd29;
  localparam logic [10:0] ROW_WORDS   = 11'd40;
  localparam logic [10:0] SCROLL_LAST = 11'd1159;
  localparam logic [10:0] LAST_WORD   = 11'd1199;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_SCROLL_RD, S_SCROLL_WR, S_SCROLL_CLR, S_CLEAR
  } state_t;

  state_t      r_state, w_state;
  logic [6:0]  r_col, w_col;
  logic [4:0]  r_row, w_row;
  logic [10:0] r_cnt, w_cnt;
  logic [3:0]  r_fcol, r_bcol;
  logic        r_we, w_we;
  logic [10:0] r_addr, w_addr;
  logic [31:0] r_wdata, w_wdata;
  logic [3:0]  r_byteen, w_byteen;
  logic        r_busy, r_ready;
  logic        w_accept;
  logic        w_printable;
  logic [15:0] w_entry;

  function automatic logic [10:0] f_word_addr(input logic [4:0] row, input logic [6:0] col);
    return ({6'd0, row} << 5) + ({6'd0, row} << 3) + {5'd0, col[6:1]};
  endfunction

  function automatic logic [31:0] f_blank(input logic [3:0] fc, input logic [3:0] bc);
    return {1'b0, 7'h20, fc, bc, 1'b0, 7'h20, fc, bc};
  endfunction

  assign w_printable = (bus.char_in >= 8'h20) && (bus.char_in <= 8'h7E);
  assign w_entry     = {bus.invert, bus.char_in[6:0], bus.fcolor_idx, bus.bcolor_idx};

  // Next state, next cursor and next (registered) VRAM port values
  always_comb begin
    w_state  = r_state;
    w_col    = r_col;
    w_row    = r_row;
    w_cnt    = r_cnt;
    w_we     = 1'b0;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_byteen = r_byteen;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.char_valid && r_ready) begin
          w_accept = 1'b1;
          if (w_printable) begin
            w_state  = S_WRITE;
            w_we     = 1'b1;
            w_addr   = f_word_addr(r_row, r_col);
            w_wdata  = r_col[0] ? {w_entry, 16'h0000} : {16'h0000, w_entry};
            w_byteen = r_col[0] ? 4'b1100 : 4'b0011;
          end else begin
            case (bus.char_in)
              8'h0A: begin
                w_col = 7'd0;
                if (r_row == LAST_ROW) begin
                  w_state = S_SCROLL_RD;
                  w_cnt   = 11'd0;
                  w_addr  = ROW_WORDS;
                end else begin
                  w_row = r_row + 5'd1;
                end
              end
              8'h0D: w_col = 7'd0;
              8'h08: begin
                if (r_col != 7'd0) begin
                  w_col = r_col - 7'd1;
                end else if (r_row != 5'd0) begin
                  w_col = LAST_COL;
                  w_row = r_row - 5'd1;
                end
              end
              8'h0C: begin
                // First blank word uses the attributes arriving with FF itself
                w_state  = S_CLEAR;
                w_cnt    = 11'd0;
                w_we     = 1'b1;
                w_addr   = 11'd0;
                w_wdata  = f_blank(bus.fcolor_idx, bus.bcolor_idx);
                w_byteen = 4'hF;
              end
              default: ;
            endcase
          end
        end
      end
      S_WRITE: begin
        if (r_col == LAST_COL) begin
          w_col = 7'd0;
          if (r_row == LAST_ROW) begin
            w_state = S_SCROLL_RD;
            w_cnt   = 11'd0;
            w_addr  = ROW_WORDS;
          end else begin
            w_row   = r_row + 5'd1;
            w_state = S_IDLE;
          end
        end else begin
          w_col   = r_col + 7'd1;
          w_state = S_IDLE;
        end
      end
      S_SCROLL_RD: begin
        w_state  = S_SCROLL_WR;
        w_we     = 1'b1;
        w_addr   = r_cnt;
        w_byteen = 4'hF;
      end
      S_SCROLL_WR: begin
        if (r_cnt == SCROLL_LAST) begin
          w_state  = S_SCROLL_CLR;
          w_cnt    = SCROLL_LAST + 11'd1;
          w_we     = 1'b1;
          w_addr   = SCROLL_LAST + 11'd1;
          w_wdata  = f_blank(r_fcol, r_bcol);
          w_byteen = 4'hF;
        end else begin
          w_state = S_SCROLL_RD;
          w_cnt   = r_cnt + 11'd1;
          w_addr  = r_cnt + 11'd1 + ROW_WORDS;
        end
      end
      S_SCROLL_CLR, S_CLEAR: begin
        if (r_cnt == LAST_WORD) begin
          w_state = S_IDLE;
          if (r_state == S_CLEAR) begin
            w_col = 7'd0;
            w_row = 5'd0;
          end
        end else begin
          w_cnt  = r_cnt + 11'd1;
          w_we   = 1'b1;
          w_addr = r_cnt + 11'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // State, cursor and output registers; reset aborts any scroll or clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_col    <= 7'd0;
      r_row    <= 5'd0;
      r_cnt    <= 11'd0;
      r_we     <= 1'b0;
      r_addr   <= 11'd0;
      r_wdata  <= 32'd0;
      r_byteen <= 4'd0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_col    <= w_col;
      r_row    <= w_row;
      r_cnt    <= w_cnt;
      r_we     <= w_we;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_byteen <= w_byteen;
      r_busy   <= (w_state != S_IDLE) && (w_state != S_WRITE);
      r_ready  <= (w_state == S_IDLE);
    end
  end

  // Attributes latched with each accepted character, used for blank words
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_fcol <= bus.fcolor_idx;
      r_bcol <= bus.bcolor_idx;
    end
  end

  // Read data only exists in the cycle after the read address, so scroll
  // copies pass it straight through instead of through r_wdata.
  assign bus.vram_wdata  = (r_state == S_SCROLL_WR) ? bus.vram_rdata : r_wdata;
  assign bus.vram_addr   = r_addr;
  assign bus.vram_byteen = r_byteen;
  assign bus.vram_we     = r_we;
  assign bus.char_ready  = r_ready;
  assign bus.busy        = r_busy;
  assign bus.cursor_col  = r_col;
  assign bus.cursor_row  = r_row;
endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer with a behavioural VRAM model.
module tb_text_console_writer;
  logic clk = 1'b0;
  logic rst;
  logic preset_req;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  text_console_writer_if bus();

  text_console_writer dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  logic [31:0] mem [0:1199];

  function automatic logic [31:0] pat(input int i);
    logic [31:0] v;
    v = i;
    return {v[15:0] ^ 16'hA5C3, v[15:0]};
  endfunction

  // VRAM model: byte-enabled write, registered read, optional pattern preset
  always @(posedge clk) begin
    if (preset_req) begin
      for (int i = 0; i < 1200; i++) mem[i] <= pat(i);
    end else if (bus.vram_we && bus.vram_addr < 11'd1200) begin
      for (int k = 0; k < 4; k++)
        if (bus.vram_byteen[k]) mem[bus.vram_addr][k*8 +: 8] <= bus.vram_wdata[k*8 +: 8];
    end
    bus.vram_rdata <= (bus.vram_addr < 11'd1200) ? mem[bus.vram_addr] : 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for ready, presents one character for one cycle.
  // Returns at the falling edge of the cycle after acceptance.
  task automatic accept(input logic [7:0] ch, input logic [3:0] f, input logic [3:0] b,
                        input logic inv);
    int k = 0;
    while (!bus.char_ready && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (!bus.char_ready) chk("ready_timeout", {31'd0, bus.char_ready}, 32'd1);
    bus.char_valid = 1'b1;
    bus.char_in    = ch;
    bus.fcolor_idx = f;
    bus.bcolor_idx = b;
    bus.invert     = inv;
    @(negedge clk);
    bus.char_valid = 1'b0;
  endtask

  // Counts busy cycles and write strobes until busy drops (bounded)
  task automatic run_busy(input logic hold, output int busy_cyc, output int wr_cyc);
    busy_cyc = 0;
    wr_cyc   = 0;
    while (bus.busy && busy_cyc < 5000) begin
      busy_cyc++;
      if (bus.vram_we) wr_cyc++;
      if (hold) begin
        bus.char_valid = 1'b1;
        bus.char_in    = 8'h51;
      end
      @(negedge clk);
    end
    bus.char_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  ch;
    logic [3:0]  f;
    logic [3:0]  b;
    logic        inv;
    logic        we;
    logic [10:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [6:0]  col;
    logic [4:0]  row;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, wc, errs;
    vecs[0]  = '{8'h41, 4'd3, 4'd0, 1'b0, 1'b1, 11'd0,  4'b0011, 32'h0000_4130, 7'd1,  5'd0};
    vecs[1]  = '{8'h42, 4'd3, 4'd0, 1'b1, 1'b1, 11'd0,  4'b1100, 32'hC230_0000, 7'd2,  5'd0};
    vecs[2]  = '{8'h0D, 4'd0, 4'd0, 1'b0, 1'b0, 11'd0,  4'b0000, 32'h0,         7'd0,  5'd0};
    vecs[3]  = '{8'h0A, 4'd0, 4'd0, 1'b0, 1'b0, 11'd0,  4'b0000, 32'h0,         7'd0,  5'd1};
    vecs[4]  = '{8'h7A, 4'hA, 4'd5, 1'b0, 1'b1, 11'd40, 4'b0011, 32'h0000_7AA5, 7'd1,  5'd1};
    vecs[5]  = '{8'h08, 4'd0, 4'd0, 1'b0, 1'b0, 11'd0,  4'b0000, 32'h0,         7'd0,  5'd1};
    vecs[6]  = '{8'h08, 4'd0, 4'd0, 1'b0, 1'b0, 11'd0,  4'b0000, 32'h0,         7'd79, 5'd0};
    vecs[7]  = '{8'h7E, 4'd1, 4'd2, 1'b1, 1'b1, 11'd39, 4'b1100, 32'hFE12_0000, 7'd0,  5'd1};
    vecs[8]  = '{8'h7F, 4'd0, 4'd0, 1'b0, 1'b0, 11'd0,  4'b0000, 32'h0,         7'd0,  5'd1};
    vecs[9]  = '{8'h1F, 4'd0, 4'd0, 1'b0, 1'b0, 11'd0,  4'b0000, 32'h0,         7'd0,  5'd1};
    vecs[10] = '{8'h20, 4'd0, 4'd0, 1'b0, 1'b1, 11'd40, 4'b0011, 32'h0000_2000, 7'd1,  5'd1};
    vecs[11] = '{8'h80, 4'd0, 4'd0, 1'b0, 1'b0, 11'd0,  4'b0000, 32'h0,         7'd1,  5'd1};
    vecs[12] = '{8'h0D, 4'd0, 4'd0, 1'b0, 1'b0, 11'd0,  4'b0000, 32'h0,         7'd0,  5'd1};

    rst = 1'b1;
    preset_req = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_in    = 8'h00;
    bus.fcolor_idx = 4'd0;
    bus.bcolor_idx = 4'd0;
    bus.invert     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_we",     {31'd0, bus.vram_we},     32'd0);
    chk("rst_addr",   {21'd0, bus.vram_addr},   32'd0);
    chk("rst_wdata",  bus.vram_wdata,           32'd0);
    chk("rst_byteen", {28'd0, bus.vram_byteen}, 32'd0);
    chk("rst_busy",   {31'd0, bus.busy},        32'd0);
    chk("rst_ready",  {31'd0, bus.char_ready},  32'd1);
    chk("rst_col",    {25'd0, bus.cursor_col},  32'd0);
    chk("rst_row",    {27'd0, bus.cursor_row},  32'd0);

    for (int i = 0; i < 13; i++) begin
      accept(vecs[i].ch, vecs[i].f, vecs[i].b, vecs[i].inv);
      chk($sformatf("v%0d_we", i), {31'd0, bus.vram_we}, {31'd0, vecs[i].we});
      if (vecs[i].we) begin
        chk($sformatf("v%0d_addr", i), {21'd0, bus.vram_addr}, {21'd0, vecs[i].addr});
        chk($sformatf("v%0d_be", i), {28'd0, bus.vram_byteen}, {28'd0, vecs[i].be});
        chk($sformatf("v%0d_wdata", i), bus.vram_wdata, vecs[i].wd);
      end
      @(negedge clk);
      chk($sformatf("v%0d_col", i), {25'd0, bus.cursor_col}, {25'd0, vecs[i].col});
      chk($sformatf("v%0d_row", i), {27'd0, bus.cursor_row}, {27'd0, vecs[i].row});
      chk($sformatf("v%0d_ready", i), {31'd0, bus.char_ready}, 32'd1);
    end

    // Last column of a middle row wraps without scrolling
    repeat (4) accept(8'h0A, 4'd0, 4'd0, 1'b0);
    repeat (79) accept(8'h20, 4'd3, 4'd0, 1'b0);
    @(negedge clk);
    chk("pos79_col", {25'd0, bus.cursor_col}, 32'd79);
    chk("pos79_row", {27'd0, bus.cursor_row}, 32'd5);
    accept(8'h78, 4'd3, 4'd0, 1'b0);
    chk("x_we",    {31'd0, bus.vram_we},     32'd1);
    chk("x_addr",  {21'd0, bus.vram_addr},   32'd239);
    chk("x_be",    {28'd0, bus.vram_byteen}, 32'hC);
    chk("x_wdata", bus.vram_wdata,           32'h7830_0000);
    @(negedge clk);
    chk("x_col",  {25'd0, bus.cursor_col}, 32'd0);
    chk("x_row",  {27'd0, bus.cursor_row}, 32'd6);
    chk("x_busy", {31'd0, bus.busy},       32'd0);

    // LF on the last row scrolls
    repeat (23) accept(8'h0A, 4'd0, 4'd0, 1'b0);
    repeat (5) accept(8'h61, 4'd3, 4'd0, 1'b0);
    @(negedge clk);
    chk("pre_scroll_col", {25'd0, bus.cursor_col}, 32'd5);
    chk("pre_scroll_row", {27'd0, bus.cursor_row}, 32'd29);
    preset_req = 1'b1;
    @(negedge clk);
    preset_req = 1'b0;
    accept(8'h0A, 4'd2, 4'd9, 1'b0);
    run_busy(1'b0, bc, wc);
    chk("lf_scroll_cycles", bc, 32'd2360);
    chk("lf_scroll_writes", wc, 32'd1200);
    errs = 0;
    for (int i = 0; i < 1160; i++) if (mem[i] !== pat(i + 40)) errs++;
    chk("lf_scroll_moved_errs", errs, 32'd0);
    errs = 0;
    for (int i = 1160; i < 1200; i++) if (mem[i] !== 32'h2029_2029) errs++;
    chk("lf_scroll_blank_errs", errs, 32'd0);
    chk("lf_scroll_col",   {25'd0, bus.cursor_col}, 32'd0);
    chk("lf_scroll_row",   {27'd0, bus.cursor_row}, 32'd29);
    chk("lf_scroll_ready", {31'd0, bus.char_ready}, 32'd1);

    // Printable at (79,29) writes, then scrolls
    repeat (79) accept(8'h61, 4'd3, 4'd0, 1'b0);
    @(negedge clk);
    accept(8'h62, 4'd3, 4'd0, 1'b0);
    chk("wrap_we",    {31'd0, bus.vram_we},   32'd1);
    chk("wrap_addr",  {21'd0, bus.vram_addr}, 32'd1199);
    chk("wrap_wdata", bus.vram_wdata,         32'h6230_0000);
    @(negedge clk);
    run_busy(1'b0, bc, wc);
    chk("wrap_scroll_cycles", bc, 32'd2360);
    chk("wrap_moved_word",    mem[1159], 32'h6230_6130);
    chk("wrap_blank_word",    mem[1199], 32'h2030_2030);
    chk("wrap_col", {25'd0, bus.cursor_col}, 32'd0);
    chk("wrap_row", {27'd0, bus.cursor_row}, 32'd29);

    // Form feed clears; valid held during busy must be ignored
    accept(8'h0C, 4'd7, 4'd1, 1'b0);
    run_busy(1'b1, bc, wc);
    chk("clr_cycles", bc, 32'd1200);
    chk("clr_writes", wc, 32'd1200);
    errs = 0;
    for (int i = 0; i < 1200; i++) if (mem[i] !== 32'h2071_2071) errs++;
    chk("clr_word_errs", errs, 32'd0);
    chk("clr_col",   {25'd0, bus.cursor_col}, 32'd0);
    chk("clr_row",   {27'd0, bus.cursor_row}, 32'd0);
    chk("clr_ready", {31'd0, bus.char_ready}, 32'd1);
    @(negedge clk);
    chk("clr_held_we",  {31'd0, bus.vram_we},    32'd0);
    chk("clr_held_col", {25'd0, bus.cursor_col}, 32'd0);

    // Backspace at home and an unused control code do nothing
    accept(8'h08, 4'd0, 4'd0, 1'b0);
    chk("bs00_we", {31'd0, bus.vram_we}, 32'd0);
    @(negedge clk);
    chk("bs00_col", {25'd0, bus.cursor_col}, 32'd0);
    chk("bs00_row", {27'd0, bus.cursor_row}, 32'd0);
    accept(8'h07, 4'd0, 4'd0, 1'b0);
    chk("bel_we", {31'd0, bus.vram_we}, 32'd0);
    @(negedge clk);
    chk("bel_col", {25'd0, bus.cursor_col}, 32'd0);
    chk("bel_row", {27'd0, bus.cursor_row}, 32'd0);

    // Reset in the middle of a clear
    accept(8'h0C, 4'd7, 4'd1, 1'b0);
    repeat (10) @(negedge clk);
    chk("midclr_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we",    {31'd0, bus.vram_we},    32'd0);
    chk("abort_busy",  {31'd0, bus.busy},       32'd0);
    chk("abort_ready", {31'd0, bus.char_ready}, 32'd1);
    chk("abort_addr",  {21'd0, bus.vram_addr},  32'd0);
    chk("abort_wdata", bus.vram_wdata,          32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_abort_we", {31'd0, bus.vram_we}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
